// File: rtl/ccsds_pkg.sv
// Shared CCSDS constants, FSM state type and the unrolled PN-sequence step.
package ccsds_pkg;

  localparam logic [7:0] CCSDS_PN_SEED     = 8'hFF;
  localparam int         CCSDS_PAYLOAD_LEN = 255;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_DROP = 1'b1
  } derand_state_e;

  // state holds a_n..a_{n+7} with a_n in the MSB; the current PN byte is the state itself.
  // Returns {state after 8 steps, current pn byte}.
  function automatic logic [15:0] pn_next8(input logic [7:0] state);
    logic [0:15] seq;
    seq[0:7] = state;
    for (int i = 0; i < 8; i++) begin
      seq[i+8] = seq[i+7] ^ seq[i+5] ^ seq[i+3] ^ seq[i];
    end
    return {seq[8:15], state};
  endfunction

endpackage

// File: rtl/ccsds_pn_lfsr.sv
// CCSDS pseudo-randomiser register: reloads the seed on load, else steps 8 bits on advance.
module ccsds_pn_lfsr
  import ccsds_pkg::*;
#(
  parameter logic [7:0] SEED = CCSDS_PN_SEED
) (
  input  logic       core_clk,
  input  logic       rst,
  input  logic       load,
  input  logic       advance,
  output logic [7:0] pn_byte
);

  logic [7:0]  lfsr_q;
  logic [15:0] step;

  assign step    = pn_next8(lfsr_q);
  assign pn_byte = step[7:0];

  always_ff @(posedge core_clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= SEED;
    end else if (load) begin
      lfsr_q <= SEED;
    end else if (advance) begin
      lfsr_q <= step[15:8];
    end
  end

endmodule

// File: rtl/ccsds_derand.sv
// CCSDS descrambler: per-frame reseeded PN XOR, frame-length enforcement and statistics.
// Handshake: a beat transfers on a rising edge where valid && ready; a valid beat holds data/last until taken.
module ccsds_derand
  import ccsds_pkg::*;
#(
  parameter int         FRAME_LEN = CCSDS_PAYLOAD_LEN,
  parameter logic [7:0] PN_SEED   = CCSDS_PN_SEED
) (
  input  logic          core_clk,
  input  logic          rst,
  input  logic          derand_en,
  input  logic [7:0]    s_axis_tdata,
  input  logic          s_axis_tvalid,
  input  logic          s_axis_tlast,
  output logic          s_axis_tready,
  output logic [7:0]    m_axis_tdata,
  output logic          m_axis_tvalid,
  output logic          m_axis_tlast,
  input  logic          m_axis_tready,
  output logic [15:0]   frame_cnt,
  output logic [15:0]   len_err_cnt,
  output logic          len_err,
  output derand_state_e dbg_state
);

  localparam logic [8:0] LAST_IDX = 9'(FRAME_LEN - 1);

  derand_state_e state;
  logic [8:0]    byte_cnt;
  logic [7:0]    pn_byte;
  logic          accept;
  logic          at_end;
  logic          run_accept;
  logic          pn_load;
  logic          pn_adv;
  logic [15:0]   len_err_inc;

  assign s_axis_tready = (state == ST_DROP) || !m_axis_tvalid || m_axis_tready;
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign at_end        = (byte_cnt == LAST_IDX);
  assign run_accept    = accept && (state == ST_RUN);
  // Any frame end (good, short or forced) reseeds so the next byte uses the seed with no bubble.
  assign pn_load       = run_accept && (s_axis_tlast || at_end);
  assign pn_adv        = run_accept && !s_axis_tlast && !at_end;
  assign len_err_inc   = (len_err_cnt == 16'hFFFF) ? len_err_cnt : len_err_cnt + 16'd1;
  assign dbg_state     = state;

  ccsds_pn_lfsr #(
    .SEED (PN_SEED)
  ) u_lfsr (
    .core_clk (core_clk),
    .rst      (rst),
    .load     (pn_load),
    .advance  (pn_adv),
    .pn_byte  (pn_byte)
  );

  always_ff @(posedge core_clk or posedge rst) begin
    if (rst) begin
      state         <= ST_RUN;
      byte_cnt      <= 9'd0;
      m_axis_tdata  <= 8'h00;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      frame_cnt     <= 16'd0;
      len_err_cnt   <= 16'd0;
      len_err       <= 1'b0;
    end else begin
      len_err <= 1'b0;
      if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
      if (state == ST_RUN) begin
        if (accept) begin
          m_axis_tvalid <= 1'b1;
          m_axis_tdata  <= s_axis_tdata ^ (derand_en ? pn_byte : 8'h00);
          m_axis_tlast  <= s_axis_tlast || at_end;
          if (s_axis_tlast) begin
            byte_cnt <= 9'd0;
            if (at_end) begin
              frame_cnt <= frame_cnt + 16'd1;
            end else begin
              len_err     <= 1'b1;
              len_err_cnt <= len_err_inc;
            end
          end else if (at_end) begin
            byte_cnt    <= 9'd0;
            len_err     <= 1'b1;
            len_err_cnt <= len_err_inc;
            state       <= ST_DROP;
          end else begin
            byte_cnt <= byte_cnt + 9'd1;
          end
        end
      end else begin
        if (accept && s_axis_tlast) begin
          state    <= ST_RUN;
          byte_cnt <= 9'd0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ccsds_derand.sv
// Self-checking bench for ccsds_derand: frame-level reference model, per-cycle output compare.
module tb_ccsds_derand;
  import ccsds_pkg::*;

  localparam int FRAME_LEN = 255;

  // ---------------- clock / reset ----------------
  logic          core_clk = 1'b0;
  logic          rst;
  logic          derand_en;
  logic [7:0]    s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tlast;
  logic          s_axis_tready;
  logic [7:0]    m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tlast;
  logic          m_axis_tready;
  logic [15:0]   frame_cnt;
  logic [15:0]   len_err_cnt;
  logic          len_err;
  derand_state_e dbg_state;

  initial forever #5 core_clk = ~core_clk;

  ccsds_derand #(
    .FRAME_LEN (FRAME_LEN),
    .PN_SEED   (8'hFF)
  ) dut (
    .core_clk      (core_clk),
    .rst           (rst),
    .derand_en     (derand_en),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready),
    .frame_cnt     (frame_cnt),
    .len_err_cnt   (len_err_cnt),
    .len_err       (len_err),
    .dbg_state     (dbg_state)
  );

  // ---------------- model state / scoreboard ----------------
  int         checks = 0;
  int         errors = 0;
  logic [7:0] pn_tab [FRAME_LEN];
  logic [8:0] exp_q [$];
  logic [7:0] out_log [$];
  logic [7:0] raw_q [$];
  int         model_pos = 0;
  bit         model_drop = 1'b0;
  int         exp_frames = 0;
  int         exp_errs = 0;
  int         pulses = 0;
  bit         mready_random = 1'b0;
  bit         gap_random = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // PN table from the bit recurrence over a whole frame, seed bits first, MSB first per byte.
  task automatic build_pn_table();
    bit         bits [$];
    logic [7:0] seed;
    logic [7:0] b;
    seed = CCSDS_PN_SEED;
    for (int i = 0; i < 8; i++) bits.push_back(seed[7-i]);
    for (int n = 0; bits.size() < 8 * FRAME_LEN; n++)
      bits.push_back(bits[n+7] ^ bits[n+5] ^ bits[n+3] ^ bits[n]);
    for (int k = 0; k < FRAME_LEN; k++) begin
      for (int j = 0; j < 8; j++) b[7-j] = bits[8*k + j];
      pn_tab[k] = b;
    end
  endtask

  // Frame-level rule model applied to each accepted input byte.
  task automatic model_accept(input logic [7:0] d, input logic l);
    if (model_drop) begin
      if (l) model_drop = 1'b0;
    end else begin
      exp_q.push_back({(l || model_pos == FRAME_LEN - 1),
                       (derand_en ? (d ^ pn_tab[model_pos]) : d)});
      if (l) begin
        if (model_pos == FRAME_LEN - 1) exp_frames++;
        else exp_errs++;
        model_pos = 0;
      end else if (model_pos == FRAME_LEN - 1) begin
        exp_errs++;
        model_drop = 1'b1;
        model_pos = 0;
      end else begin
        model_pos++;
      end
    end
  endtask

  // ---------------- driver tasks (called at negedge) ----------------
  task automatic send_byte(input logic [7:0] d, input logic l);
    int  wait_cyc = 0;
    bit  done = 1'b0;
    if (gap_random && $urandom_range(0, 3) == 0) @(negedge core_clk);
    if (model_drop) check("drop_ready", 32'(s_axis_tready), 32'd1);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    s_axis_tlast  = l;
    while (!done) begin
      if (s_axis_tready) done = 1'b1;
      @(posedge core_clk);
      if (!done) begin
        wait_cyc++;
        if (wait_cyc > 2000) begin
          $display("FAIL input_stall actual=%0d required<=2000", wait_cyc);
          $fatal(1, "input handshake stuck");
        end
        @(negedge core_clk);
      end
    end
    model_accept(d, l);
    @(negedge core_clk);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  // mode 0: zeros, 1: random, 2: scrambled random (raw kept in raw_q)
  task automatic send_frame(input int n, input int last_at, input int mode);
    logic [7:0] r;
    for (int i = 0; i < n; i++) begin
      r = 8'($urandom_range(0, 255));
      if (mode == 0) send_byte(8'h00, i == last_at);
      else if (mode == 1) send_byte(r, i == last_at);
      else begin
        raw_q.push_back(r);
        send_byte(r ^ pn_tab[i % FRAME_LEN], i == last_at);
      end
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 5000) begin
      @(negedge core_clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout actual=%0d required=0", exp_q.size());
      exp_q.delete();
    end
    repeat (3) @(negedge core_clk);
  endtask

  task automatic check_counters(input string tag);
    check({tag, "_frame_cnt"}, 32'(frame_cnt), 32'(exp_frames));
    check({tag, "_len_err_cnt"}, 32'(len_err_cnt), 32'(exp_errs));
    check({tag, "_len_err_pulses"}, 32'(pulses), 32'(exp_errs));
  endtask

  task automatic check_reset_vals();
    check("rst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("rst_m_tdata", 32'(m_axis_tdata), 32'd0);
    check("rst_m_tlast", 32'(m_axis_tlast), 32'd0);
    check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    check("rst_len_err_cnt", 32'(len_err_cnt), 32'd0);
    check("rst_len_err", 32'(len_err), 32'd0);
  endtask

  task automatic check_seed_start(input string tag, input int idx);
    check({tag, "_b0"}, 32'(out_log[idx]), 32'h00FF);
    check({tag, "_b1"}, 32'(out_log[idx+1]), 32'h0048);
  endtask

  // ---------------- downstream ready ----------------
  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(posedge core_clk);
      #2;
      m_axis_tready = mready_random ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // ---------------- compare process ----------------
  initial begin
    logic [8:0] e;
    bit         prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic       prev_last = 1'b0;
    forever begin
      @(negedge core_clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (len_err) pulses++;
        if (prev_stall) begin
          check("stall_valid", 32'(m_axis_tvalid), 32'd1);
          check("stall_data", 32'(m_axis_tdata), 32'(prev_data));
          check("stall_last", 32'(m_axis_tlast), 32'(prev_last));
        end
        if (m_axis_tvalid && m_axis_tready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_beat", 32'(m_axis_tdata), 32'h100);
          end else begin
            e = exp_q.pop_front();
            check("out_data", 32'(m_axis_tdata), 32'(e[7:0]));
            check("out_last", 32'(m_axis_tlast), 32'(e[8]));
          end
          out_log.push_back(m_axis_tdata);
        end
        prev_stall = m_axis_tvalid && !m_axis_tready;
        prev_data  = m_axis_tdata;
        prev_last  = m_axis_tlast;
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [7:0] exp8 [8];
    int         base;
    exp8 = '{8'hFF, 8'h48, 8'h0E, 8'hC0, 8'h9A, 8'h0D, 8'h70, 8'hBC};
    rst = 1'b1;
    derand_en = 1'b1;
    s_axis_tvalid = 1'b0;
    s_axis_tdata = 8'h00;
    s_axis_tlast = 1'b0;
    build_pn_table();
    repeat (3) @(negedge core_clk);
    check_reset_vals();
    rst = 1'b0;
    @(negedge core_clk);

    for (int i = 0; i < 8; i++) check("model_pn_tab", 32'(pn_tab[i]), 32'(exp8[i]));

    // Good zero frame: output is the PN sequence itself.
    base = out_log.size();
    send_frame(255, 254, 0);
    drain();
    for (int i = 0; i < 8; i++) check("good_pn_byte", 32'(out_log[base+i]), 32'(exp8[i]));
    check("good_out_count", 32'(out_log.size() - base), 32'd255);
    check_counters("good");

    // Back-to-back zero frames, then scrambled round trip.
    base = out_log.size();
    send_frame(255, 254, 0);
    send_frame(255, 254, 0);
    drain();
    check_seed_start("b2b_second", base + 255);
    base = out_log.size();
    raw_q.delete();
    send_frame(255, 254, 2);
    drain();
    for (int i = 0; i < 255; i++) check("roundtrip", 32'(out_log[base+i]), 32'(raw_q[i]));
    check_counters("b2b");

    // Backpressure across 3 frames.
    mready_random = 1'b1;
    gap_random = 1'b1;
    base = out_log.size();
    for (int f = 0; f < 3; f++) send_frame(255, 254, 1);
    drain();
    mready_random = 1'b0;
    gap_random = 1'b0;
    @(negedge core_clk);
    check("bp_out_count", 32'(out_log.size() - base), 32'd765);
    check("bp_frame_cnt", 32'(frame_cnt), 32'd7);
    check_counters("bp");

    // Short frame, then a good frame starting from the seed.
    base = out_log.size();
    send_frame(100, 99, 1);
    send_frame(255, 254, 0);
    drain();
    check("short_out_count", 32'(out_log.size() - base), 32'd355);
    check_seed_start("after_short", base + 100);
    check("short_len_err_cnt", 32'(len_err_cnt), 32'd1);
    check_counters("short");

    // Long frame: 255 out with forced tlast, 45 dropped, then a good frame.
    base = out_log.size();
    send_frame(300, 299, 0);
    send_frame(255, 254, 0);
    drain();
    check("long_out_count", 32'(out_log.size() - base), 32'd510);
    check_seed_start("after_long", base + 255);
    check("long_len_err_cnt", 32'(len_err_cnt), 32'd2);
    check_counters("long");

    // Bypass: output equals input.
    derand_en = 1'b0;
    base = out_log.size();
    send_frame(255, 254, 1);
    drain();
    check_counters("bypass");
    derand_en = 1'b1;

    // Reset mid-frame at byte 50, then a fresh frame from seed FF.
    send_frame(50, -1, 1);
    #2;
    rst = 1'b1;
    #1;
    exp_q.delete();
    model_pos = 0;
    model_drop = 1'b0;
    exp_frames = 0;
    exp_errs = 0;
    pulses = 0;
    @(negedge core_clk);
    check_reset_vals();
    @(negedge core_clk);
    rst = 1'b0;
    @(negedge core_clk);
    base = out_log.size();
    send_frame(255, 254, 0);
    drain();
    check_seed_start("after_reset", base);
    check("after_reset_frame_cnt", 32'(frame_cnt), 32'd1);
    check_counters("after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ccsds_derand.md
# ccsds_derand

Descrambler stage that sits directly downstream of the sync-marker stripper. It consumes the 8-bit payload stream (255-byte frames delimited by tlast) and XORs each byte with the CCSDS pseudo-randomiser sequence, reseeded at every frame boundary. It also enforces the frame length and emits frame and error statistics. Its output feeds the decoder input.

## Interface
Parameters:
- FRAME_LEN, 255: payload bytes per frame. Legal range is 2..256.
- PN_SEED, 8'hFF: LFSR state loaded at reset and at every frame start.

Ports:
- core_clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- derand_en  in  1  1 = XOR with PN; 0 = pass-through. Length checking stays active in both modes. Treated as static; change only between frames.
- s_axis_tdata  in  8  payload byte
- s_axis_tvalid  in  1  input valid
- s_axis_tlast  in  1  last byte of frame
- s_axis_tready  out  1  input ready
- m_axis_tdata  out  8  descrambled byte
- m_axis_tvalid  out  1  output valid
- m_axis_tlast  out  1  last byte of output frame
- m_axis_tready  in  1  downstream ready
- frame_cnt  out  16  good frames emitted; wraps
- len_err_cnt  out  16  length errors; saturates at 16'hFFFF
- len_err  out  1  one-cycle pulse on each length error

## Operation
- **PN sequence**: bits a_n with a_{n+8} = a_{n+7} ^ a_{n+5} ^ a_{n+3} ^ a_n (h(x) = x^8+x^7+x^5+x^3+1).
  - a_0..a_7 come from PN_SEED (MSB first).
  - Byte k of a frame is bits a_{8k}..a_{8k+7}, MSB first.
  - With the default seed the sequence starts FF 48 0E C0 9A 0D 70 BC.
  - The LFSR advances 8 steps per accepted byte, in a single cycle (unrolled).
- **Accept**: a byte is accepted when s_axis_tvalid && s_axis_tready.
- **Data path**: m_tdata = s_tdata ^ pn_byte when derand_en = 1, otherwise s_tdata.
- **Byte counter**: byte_cnt runs 0..FRAME_LEN-1 and is 9 bits wide.
- **FSM**:
  - **RUN** (reset state): pass bytes and advance byte_cnt and the LFSR.
    - Input tlast at byte_cnt == FRAME_LEN-1: good frame. Output tlast=1, frame_cnt+1, reload seed, byte_cnt=0.
    - Input tlast at byte_cnt < FRAME_LEN-1: short frame. Pass the byte with tlast=1, pulse len_err, len_err_cnt+1, reload seed, byte_cnt=0. frame_cnt is not incremented.
    - byte_cnt == FRAME_LEN-1 without input tlast: long frame. Output this byte with a forced tlast=1, pulse len_err, len_err_cnt+1, reload seed, go to DROP.
  - **DROP**: s_axis_tready=1 and nothing is written to the output. Bytes are discarded up to and including the next input tlast, then return to RUN with byte_cnt=0.
- **Counter events**: frame_cnt and len_err_cnt update, and len_err pulses, in the cycle after the tlast byte is accepted. This is the same edge on which the output register loads that byte.

## Timing
- **Latency**: one registered output stage. An accepted byte appears on m_axis in the next cycle.
- **Ready**:
  - RUN: s_axis_tready = !m_axis_tvalid || m_axis_tready (combinational).
  - DROP: s_axis_tready = 1.
- **Full rate**: one byte per cycle when m_axis_tready is held high.
- **Stall**: when m_axis_tvalid=1 and m_axis_tready=0, tdata, tvalid and tlast hold stable.
- **Reset values**:
  - m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0
  - frame_cnt=0, len_err_cnt=0, len_err=0
  - LFSR=PN_SEED, byte_cnt=0, state=RUN
  - Reset mid-frame drops the partial frame; the next accepted byte is byte 0.
- **Single-byte frame edge case**: tlast accepted on byte_cnt=0 (with FRAME_LEN ≥ 2) is a short frame.
- **No bubble**: tlast followed immediately by a new byte in the next cycle uses the seed for that byte, with no gap.

## Structure
- Shared package ccsds_pkg holds:
  - CCSDS_PN_SEED = 8'hFF
  - CCSDS_PAYLOAD_LEN = 255
  - function pn_next8(state) returning {next_state, pn_byte}
- Sub-module ccsds_pn_lfsr holds the LFSR register with inputs load and advance, and output pn_byte.
- Everything else (FSM, counters, output register) lives in the top module.

## Test plan
- **Good frame**: one 255-byte all-zero frame with tlast on byte 254, m_ready=1.
  - Output equals the PN sequence starting FF 48 0E C0 9A 0D 70 BC.
  - tlast only on the 255th output byte.
  - frame_cnt=1, len_err_cnt=0.
- **Back-to-back and round-trip**: two back-to-back zero frames → the second frame again starts FF 48. Then scrambled random data in → original data out, byte-exact.
- **Backpressure**: random m_ready with 50% duty across 3 frames → no loss or duplication, data stable while stalled, 765 bytes out, frame_cnt=3.
- **Short frame**: 100-byte frame (tlast on byte 99) followed by a good frame.
  - 100 bytes out with tlast on the last one.
  - len_err pulses once; len_err_cnt=1.
  - The next frame starts FF 48.
- **Long frame**: 300 bytes with tlast on byte 299.
  - 255 bytes out with a forced tlast.
  - 45 bytes dropped with s_ready=1.
  - len_err_cnt=1, frame_cnt=0; the next frame decodes correctly.
- **Bypass and reset**: derand_en=0 → output equals input. Assert rst mid-frame (byte 50) → all outputs return to reset values, and the following frame decodes from seed FF.
